stream_checker: RTL and testbench

//  Consumes the 32-bit incrementing test stream (word + one-cycle valid strobe) on its way back from SDRAM.

---
 rtl/stream_checker.sv | 144 ++++++++++++++
 tb/tb_stream_checker.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/stream_checker.sv
// stream_checker: verifies the 32-bit incrementing read-back stream from SDRAM.
// Seeds on the first word after enable (or clr), then checks every later word
// against the running expected value. Counts words and mismatches, captures the
// first failing pair and flags stream stalls with a gap watchdog.
// Optional feature: define STREAM_CHECKER_RESYNC_EN to re-lock the expected value
// to the received word on every check (a single bad word then costs two errors).
module stream_checker #(
   parameter int unsigned TIMEOUT = 64,
   parameter int unsigned CNT_W   = 32
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             en,
   input  logic             clr,
   input  logic [31:0]      s32,
   input  logic             n32rdy,
   output logic [CNT_W-1:0] word_cnt,
   output logic [15:0]      err_cnt,
   output logic             err_flag,
   output logic             stall_flag,
   output logic [31:0]      first_exp,
   output logic [31:0]      first_got,
   output logic             busy
);

   localparam int unsigned GapW = $clog2(TIMEOUT + 1);
   localparam logic [GapW-1:0] GapMax = GapW'(TIMEOUT);

   typedef enum logic [1:0] {StIdle, StSeed, StCheck} state_e;

   state_e           state_q, state_d;
   logic [31:0]      exp_q, exp_d;
   logic [GapW-1:0]  gap_q, gap_d;
   logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
   logic [15:0]      err_cnt_q, err_cnt_d;
   logic             err_flag_q, err_flag_d;
   logic             stall_q, stall_d;
   logic [31:0]      first_exp_q, first_exp_d;
   logic [31:0]      first_got_q, first_got_d;
   logic             busy_q, busy_d;

   // Next-state: reset handled in the register; clr beats en, en beats strobes.
   always_comb begin
      state_d     = state_q;
      exp_d       = exp_q;
      gap_d       = gap_q;
      word_cnt_d  = word_cnt_q;
      err_cnt_d   = err_cnt_q;
      err_flag_d  = err_flag_q;
      stall_d     = stall_q;
      first_exp_d = first_exp_q;
      first_got_d = first_got_q;

      if (clr) begin
         word_cnt_d  = '0;
         err_cnt_d   = '0;
         err_flag_d  = 1'b0;
         stall_d     = 1'b0;
         first_exp_d = '0;
         first_got_d = '0;
         gap_d       = '0;
         state_d     = en ? StSeed : StIdle;
      end else if (!en) begin
         state_d = StIdle;
         gap_d   = '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               state_d = StSeed;
               gap_d   = '0;
            end
            StSeed: begin
               gap_d = '0;
               if (n32rdy) begin
                  exp_d   = s32 + 32'd1;
                  state_d = StCheck;
                  if (!(&word_cnt_q)) word_cnt_d = word_cnt_q + CNT_W'(1);
               end
            end
            StCheck: begin
               if (n32rdy) begin
                  gap_d = '0;
                  if (!(&word_cnt_q)) word_cnt_d = word_cnt_q + CNT_W'(1);
                  if (s32 != exp_q) begin
                     if (!(&err_cnt_q)) err_cnt_d = err_cnt_q + 16'd1;
                     err_flag_d = 1'b1;
                     // Capture only the very first failing pair.
                     if (!err_flag_q) begin
                        first_exp_d = exp_q;
                        first_got_d = s32;
                     end
                  end
`ifdef STREAM_CHECKER_RESYNC_EN
                  exp_d = s32 + 32'd1;
`else
                  exp_d = exp_q + 32'd1;
`endif
               end else if (gap_q != GapMax) begin
                  gap_d = gap_q + GapW'(1);
                  if (gap_d == GapMax) stall_d = 1'b1;
               end
            end
            default: state_d = StIdle;
         endcase
      end
      busy_d = (state_d == StCheck);
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state_q     <= StIdle;
         exp_q       <= '0;
         gap_q       <= '0;
         word_cnt_q  <= '0;
         err_cnt_q   <= '0;
         err_flag_q  <= 1'b0;
         stall_q     <= 1'b0;
         first_exp_q <= '0;
         first_got_q <= '0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         exp_q       <= exp_d;
         gap_q       <= gap_d;
         word_cnt_q  <= word_cnt_d;
         err_cnt_q   <= err_cnt_d;
         err_flag_q  <= err_flag_d;
         stall_q     <= stall_d;
         first_exp_q <= first_exp_d;
         first_got_q <= first_got_d;
         busy_q      <= busy_d;
      end
   end

   assign word_cnt   = word_cnt_q;
   assign err_cnt    = err_cnt_q;
   assign err_flag   = err_flag_q;
   assign stall_flag = stall_q;
   assign first_exp  = first_exp_q;
   assign first_got  = first_got_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_stream_checker.sv
// Scoreboard bench for stream_checker: stimulus pushes the reference model's
// expected outputs per cycle, a monitor pops and compares after each edge.
module tb_stream_checker;

   localparam int unsigned TIMEOUT = 64;
   localparam int unsigned CNT_W   = 8;
   localparam int WC_MAX = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             n_rst = 1'b0;
   logic             en = 1'b1;
   logic             clr = 1'b0;
   logic [31:0]      s32 = '0;
   logic             n32rdy = 1'b0;
   logic [CNT_W-1:0] word_cnt;
   logic [15:0]      err_cnt;
   logic             err_flag, stall_flag, busy;
   logic [31:0]      first_exp, first_got;

   stream_checker #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
      .clk(clk), .n_rst(n_rst), .en(en), .clr(clr), .s32(s32), .n32rdy(n32rdy),
      .word_cnt(word_cnt), .err_cnt(err_cnt), .err_flag(err_flag),
      .stall_flag(stall_flag), .first_exp(first_exp), .first_got(first_got), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic             busy;
      logic [CNT_W-1:0] wc;
      logic [15:0]      ec;
      logic             ef;
      logic             sf;
      logic [31:0]      fe;
      logic [31:0]      fg;
   } obs_t;

   obs_t q[$];
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;

   // Reference model: checker phase plus plain integer counters.
   localparam int PH_IDLE = 0, PH_SEED = 1, PH_CHECK = 2;
   int          m_phase = PH_IDLE;
   logic [31:0] m_exp = '0;
   int          m_gap = 0;
   int          m_wc = 0;
   int          m_ec = 0;
   bit          m_ef = 0, m_sf = 0;
   logic [31:0] m_fe = '0, m_fg = '0;

   task automatic model_step(input bit r, input bit e, input bit c, input bit v,
                             input logic [31:0] d);
      if (!r) begin
         m_phase = PH_IDLE; m_exp = 0; m_gap = 0; m_wc = 0; m_ec = 0;
         m_ef = 0; m_sf = 0; m_fe = 0; m_fg = 0;
      end else if (c) begin
         m_wc = 0; m_ec = 0; m_ef = 0; m_sf = 0; m_fe = 0; m_fg = 0; m_gap = 0;
         m_phase = e ? PH_SEED : PH_IDLE;
      end else if (!e) begin
         m_phase = PH_IDLE; m_gap = 0;
      end else if (m_phase == PH_IDLE) begin
         m_phase = PH_SEED; m_gap = 0;
      end else if (m_phase == PH_SEED) begin
         m_gap = 0;
         if (v) begin
            m_exp = d + 1;
            if (m_wc < WC_MAX) m_wc++;
            m_phase = PH_CHECK;
         end
      end else begin
         if (v) begin
            m_gap = 0;
            if (m_wc < WC_MAX) m_wc++;
            if (d != m_exp) begin
               if (m_ec < 65535) m_ec++;
               if (!m_ef) begin m_fe = m_exp; m_fg = d; end
               m_ef = 1;
            end
`ifdef STREAM_CHECKER_RESYNC_EN
            m_exp = d + 1;
`else
            m_exp = m_exp + 1;
`endif
         end else begin
            if (m_gap < TIMEOUT) m_gap++;
            if (m_gap == TIMEOUT) m_sf = 1;
         end
      end
   endtask

   // One clock of stimulus: drive at negedge, predict, enqueue expectation.
   task automatic drive(input bit r, input bit e, input bit c, input bit v,
                        input logic [31:0] d);
      obs_t o;
      @(negedge clk);
      n_rst = r; en = e; clr = c; n32rdy = v; s32 = d;
      model_step(r, e, c, v, d);
      o.busy = (m_phase == PH_CHECK);
      o.wc = CNT_W'(m_wc);
      o.ec = 16'(m_ec);
      o.ef = m_ef;
      o.sf = m_sf;
      o.fe = m_fe;
      o.fg = m_fg;
      q.push_back(o);
   endtask

   task automatic send(input logic [31:0] d, input int idle);
      drive(1, 1, 0, 1, d);
      repeat (idle) drive(1, 1, 0, 0, $urandom);
   endtask

   // Monitor: compare every cycle's registered outputs against the queue head.
   always @(posedge clk) begin
      obs_t exp_o, got_o;
      #1;
      cyc++;
      if (q.size() > 0) begin
         exp_o = q.pop_front();
         got_o = '{busy, word_cnt, err_cnt, err_flag, stall_flag, first_exp, first_got};
         checks++;
         if (got_o !== exp_o) begin
            failures++;
            $display("FAIL outputs cycle=%0d got busy=%0b wc=%0d ec=%0d ef=%0b sf=%0b fe=%h fg=%h required busy=%0b wc=%0d ec=%0d ef=%0b sf=%0b fe=%h fg=%h",
                     cyc, got_o.busy, got_o.wc, got_o.ec, got_o.ef, got_o.sf, got_o.fe,
                     got_o.fg, exp_o.busy, exp_o.wc, exp_o.ec, exp_o.ef, exp_o.sf,
                     exp_o.fe, exp_o.fg);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog time limit expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] nxt;
      bit e, c, v;
      int r;

      // Reset with enable and strobes active.
      repeat (2) drive(0, 1, 0, 1, $urandom);

      // Seed FAFBFCFD then 100 increments, one strobe every 8 clk.
      drive(1, 1, 0, 0, 0);
      nxt = 32'hFAFBFCFD;
      for (int i = 0; i < 101; i++) begin
         send(nxt, 7);
         nxt++;
      end

      // Wrap-around across 32'hFFFFFFFF.
      drive(1, 1, 1, 0, 0);
      send(32'hFFFFFFFE, 0); send(32'hFFFFFFFF, 0); send(32'h0, 0); send(32'h1, 2);

      // Jump in the stream: 10,11,20,21,22.
      drive(1, 1, 1, 0, 0);
      send(10, 0); send(11, 0); send(20, 0); send(21, 1); send(22, 2);

      // Gap watchdog: 70 idle cycles in CHECK, then resume.
      drive(1, 1, 1, 0, 0);
      send(5, 0); send(6, 70); send(7, 2);

      // clr with same-cycle strobe, reseed, then en drop mid-CHECK.
      drive(1, 1, 1, 1, 32'h1234);
      send(100, 0); send(101, 0); send(500, 1);
      repeat (4) drive(1, 0, 0, 1, $urandom);
      drive(1, 1, 0, 1, 77);
      send(900, 0); send(901, 0); send(902, 3);

      // word_cnt saturation: 300 back-to-back good words.
      drive(1, 1, 1, 0, 0);
      nxt = $urandom;
      for (int i = 0; i < 300; i++) begin
         send(nxt, 0);
         nxt++;
      end

      // Randomised traffic with corruption, skips, en drops, clr and long gaps.
      nxt = $urandom;
      for (int i = 0; i < 1500; i++) begin
         e = ($urandom_range(0, 49) != 0);
         c = ($urandom_range(0, 199) == 0);
         v = ($urandom_range(0, 1) == 1);
         r = $urandom_range(0, 19);
         if (!v) begin
            drive(1, e, c, 0, $urandom);
         end else if (r == 0) begin
            drive(1, e, c, 1, $urandom);
            nxt++;
         end else if (r == 1) begin
            drive(1, e, c, 1, nxt + 1);
            nxt += 2;
         end else begin
            drive(1, e, c, 1, nxt);
            nxt++;
         end
         if ($urandom_range(0, 299) == 0) repeat (70) drive(1, 1, 0, 0, $urandom);
      end

      repeat (3) drive(1, 1, 0, 0, 0);
      repeat (3) @(negedge clk);
      checks++;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL drain queue_left=%0d required=0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
